// File: rtl/ocp_arb2_if.sv
// Bundle of OCP signals between two masters, the arbiter and the shared slave.
// The slave modport is the arbiter's view; the master modport is the surrounding system's view.
interface ocp_arb2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4
);
    logic [ADDR_WIDTH-1:0] i_M0Addr;
    logic [ADDR_WIDTH-1:0] i_M1Addr;
    logic [2:0]            i_M0Cmd;
    logic [2:0]            i_M1Cmd;
    logic [DATA_WIDTH-1:0] i_M0Data;
    logic [DATA_WIDTH-1:0] i_M1Data;
    logic [BEN_WIDTH-1:0]  i_M0ByteEn;
    logic [BEN_WIDTH-1:0]  i_M1ByteEn;
    logic                  o_S0CmdAccept;
    logic                  o_S1CmdAccept;
    logic [DATA_WIDTH-1:0] o_S0Data;
    logic [DATA_WIDTH-1:0] o_S1Data;
    logic [1:0]            o_S0Resp;
    logic [1:0]            o_S1Resp;
    logic [ADDR_WIDTH-1:0] o_MAddr;
    logic [2:0]            o_MCmd;
    logic [DATA_WIDTH-1:0] o_MData;
    logic [BEN_WIDTH-1:0]  o_MByteEn;
    logic                  i_SCmdAccept;
    logic [DATA_WIDTH-1:0] i_SData;
    logic [1:0]            i_SResp;

    modport slave (
        input  i_M0Addr, i_M1Addr, i_M0Cmd, i_M1Cmd, i_M0Data, i_M1Data,
               i_M0ByteEn, i_M1ByteEn, i_SCmdAccept, i_SData, i_SResp,
        output o_S0CmdAccept, o_S1CmdAccept, o_S0Data, o_S1Data, o_S0Resp, o_S1Resp,
               o_MAddr, o_MCmd, o_MData, o_MByteEn
    );

    modport master (
        output i_M0Addr, i_M1Addr, i_M0Cmd, i_M1Cmd, i_M0Data, i_M1Data,
               i_M0ByteEn, i_M1ByteEn, i_SCmdAccept, i_SData, i_SResp,
        input  o_S0CmdAccept, o_S1CmdAccept, o_S0Data, o_S1Data, o_S0Resp, o_S1Resp,
               o_MAddr, o_MCmd, o_MData, o_MByteEn
    );
endinterface

// File: rtl/ocp_arb2.sv
// Two-master OCP arbiter in front of a single-outstanding shared slave, with read timeout.
// Define OCP_ARB_RR_EN for round-robin tie breaking; otherwise master 0 has fixed priority.
module ocp_arb2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int BEN_WIDTH  = 4,
    parameter int TMO_CYCLES = 16
) (
    input logic        clk,
    input logic        rst,
    ocp_arb2_if.slave  bus
);
    typedef enum logic [1:0] {ST_IDLE, ST_CMD, ST_RESP} state_t;

    localparam logic [2:0] CMD_IDLE  = 3'd0;
    localparam logic [2:0] CMD_READ  = 3'd2;
    localparam logic [1:0] RESP_NULL = 2'd0;
    localparam logic [1:0] RESP_ERR  = 2'd3;
    localparam logic [7:0] TMO_LAST  = 8'(TMO_CYCLES - 1);

    state_t          state_q, state_d;
    logic            grant_q, grant_d;
    logic [7:0]      cnt_q, cnt_d;
    logic            req0, req1, winner;

    logic [ADDR_WIDTH-1:0] gAddr;
    logic [2:0]            gCmd;
    logic [DATA_WIDTH-1:0] gData;
    logic [BEN_WIDTH-1:0]  gBen;
    logic                  gAccept;
    logic [1:0]            gResp;
    logic [DATA_WIDTH-1:0] gRdData;

    assign req0 = (bus.i_M0Cmd != CMD_IDLE);
    assign req1 = (bus.i_M1Cmd != CMD_IDLE);

    assign gAddr = grant_q ? bus.i_M1Addr   : bus.i_M0Addr;
    assign gCmd  = grant_q ? bus.i_M1Cmd    : bus.i_M0Cmd;
    assign gData = grant_q ? bus.i_M1Data   : bus.i_M0Data;
    assign gBen  = grant_q ? bus.i_M1ByteEn : bus.i_M0ByteEn;

`ifdef OCP_ARB_RR_EN
    logic lastGrant_q, lastGrant_d;
    // On a tie the master that did not win last time goes first.
    assign winner = (req0 && req1) ? ~lastGrant_q : ~req0;
`else
    assign winner = ~req0;
`endif

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
`ifdef OCP_ARB_RR_EN
        lastGrant_d = lastGrant_q;
`endif
        bus.o_MAddr   = '0;
        bus.o_MCmd    = CMD_IDLE;
        bus.o_MData   = '0;
        bus.o_MByteEn = '0;
        gAccept       = 1'b0;
        gResp         = RESP_NULL;
        gRdData       = '0;
        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    state_d = ST_CMD;
                    grant_d = winner;
`ifdef OCP_ARB_RR_EN
                    lastGrant_d = winner;
`endif
                end
            end
            ST_CMD: begin
                bus.o_MAddr   = gAddr;
                bus.o_MCmd    = gCmd;
                bus.o_MData   = gData;
                bus.o_MByteEn = gBen;
                gAccept       = bus.i_SCmdAccept;
                // A granted master that withdraws its command simply releases the bus.
                if (gCmd == CMD_IDLE) begin
                    state_d = ST_IDLE;
                end else if (bus.i_SCmdAccept) begin
                    if (gCmd == CMD_READ) begin
                        state_d = ST_RESP;
                        cnt_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
            end
            ST_RESP: begin
                if (bus.i_SResp != RESP_NULL) begin
                    gResp   = bus.i_SResp;
                    gRdData = bus.i_SData;
                    state_d = ST_IDLE;
                end else if (cnt_q == TMO_LAST) begin
                    gResp   = RESP_ERR;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        bus.o_S0CmdAccept = gAccept & ~grant_q;
        bus.o_S1CmdAccept = gAccept &  grant_q;
        bus.o_S0Resp      = grant_q ? RESP_NULL : gResp;
        bus.o_S1Resp      = grant_q ? gResp : RESP_NULL;
        bus.o_S0Data      = grant_q ? '0 : gRdData;
        bus.o_S1Data      = grant_q ? gRdData : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= 1'b0;
            cnt_q   <= '0;
`ifdef OCP_ARB_RR_EN
            lastGrant_q <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
`ifdef OCP_ARB_RR_EN
            lastGrant_q <= lastGrant_d;
`endif
        end
    end
endmodule
